alu_seq_nbit: RTL and testbench

- Parametrised multi-cycle successor of the 1-bit, four-mode ALU cell.
- Processes a WIDTH-bit operand pair SLICE bits per clock, LSB slice first. Carry and compare state are held in registers between slices.
- Same mode set as the cell: add, subtract, compare, AND. Same F/Cout/N output semantics, plus a zero flag.
- Valid/ready handshakes on input and output, so it slots between a register file and a writeback stage.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_nbit_slice.sv | 54 +++++
 rtl/alu_seq_nbit.sv | 178 +++++++++++++++++
 tb/tb_alu_seq_nbit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the slice-serial ALU: mode codes, FSM states and
// the signed-compare/overflow build switch (macro ALU_SEQ_SIGNED_EN).
package alu_seq_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;
  localparam logic [1:0] MODE_AND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

`ifdef ALU_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

endpackage

// File: rtl/alu_seq_nbit_slice.sv
// Combinational SLICE-bit datapath of the slice-serial ALU.
// With ALU_SEQ_SIGNED_EN the top slice compares with operand MSBs inverted.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int unsigned SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             top,
  output logic [SLICE-1:0] f,
  output logic             cout,
  output logic             cmsb,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Ripple adder (B inverted for subtract), AND, and slice magnitude compare
  always_comb begin
    logic [SLICE:0]   c;
    logic [SLICE-1:0] bx;
    logic [SLICE-1:0] sum;
    logic [SLICE-1:0] ac;
    logic [SLICE-1:0] bc;
    bx   = (mode == MODE_SUB) ? ~b : b;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SLICE); i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    ac = a;
    bc = b;
    if (top && SIGNED_EN) begin
      ac[SLICE-1] = ~a[SLICE-1];
      bc[SLICE-1] = ~b[SLICE-1];
    end
    case (mode)
      MODE_CMP: f = '0;
      MODE_AND: f = a & b;
      default:  f = sum;
    endcase
    cout = c[SLICE];
    cmsb = c[SLICE-1];
    gt   = (ac > bc);
    lt   = (ac < bc);
    eq   = (ac == bc);
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Slice-serial four-mode ALU (add/sub/compare/AND) with valid/ready handshakes.
// Processes SLICE bits per clock, LSB slice first. Build option: ALU_SEQ_SIGNED_EN
// enables two's-complement compare and the V (signed overflow) flag.
module alu_seq_nbit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [1:0]       M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_d;
  logic               load_c, step_c, finish_c;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [1:0]         m_q;
  logic               carry_q, gt_q, lt_q, eq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_c;
  int unsigned        base_c;
  logic [SLICE-1:0]   sl_f;
  logic               sl_cout, sl_cmsb, sl_gt, sl_lt, sl_eq;
  logic [WIDTH-1:0]   res_fin_c;
  logic               gt_fin_c, lt_fin_c, eq_fin_c;

  assign last_c = (cnt_q == CNT_W'(NSLICE - 1));
  assign base_c = 32'(cnt_q) * SLICE;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[base_c +: SLICE]),
    .b    (b_q[base_c +: SLICE]),
    .cin  (carry_q),
    .mode (m_q),
    .top  (last_c),
    .f    (sl_f),
    .cout (sl_cout),
    .cmsb (sl_cmsb),
    .gt   (sl_gt),
    .lt   (sl_lt),
    .eq   (sl_eq)
  );

  // Final result and compare flags including the slice being processed now
  always_comb begin
    res_fin_c                      = res_q;
    res_fin_c[base_c +: SLICE]     = sl_f;
    gt_fin_c                       = sl_eq ? gt_q : sl_gt;
    lt_fin_c                       = sl_eq ? lt_q : sl_lt;
    eq_fin_c                       = sl_eq ? eq_q : 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and datapath enables
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          finish_c = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_HOLD);
    end
  end

  // Operand capture, per-slice carry/compare/result update, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= MODE_ADD;
      res_q   <= '0;
      carry_q <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      cnt_q   <= '0;
      F       <= '0;
      Cout    <= 1'b0;
      N       <= 1'b0;
      Z       <= 1'b0;
      V       <= 1'b0;
    end else begin
      if (load_c) begin
        a_q     <= A;
        b_q     <= B;
        m_q     <= M;
        res_q   <= '0;
        carry_q <= (M == MODE_SUB) ? ~Cin : Cin;
        gt_q    <= 1'b0;
        lt_q    <= 1'b0;
        eq_q    <= 1'b1;
        cnt_q   <= '0;
      end
      if (step_c) begin
        res_q[base_c +: SLICE] <= sl_f;
        carry_q                <= sl_cout;
        gt_q                   <= gt_fin_c;
        lt_q                   <= lt_fin_c;
        eq_q                   <= eq_fin_c;
        cnt_q                  <= cnt_q + CNT_W'(1);
      end
      if (finish_c) begin
        case (m_q)
          MODE_CMP: begin
            F    <= WIDTH'(eq_fin_c);
            Cout <= gt_fin_c;
            N    <= lt_fin_c;
            Z    <= 1'b0;
            V    <= 1'b0;
          end
          MODE_AND: begin
            F    <= res_fin_c;
            Cout <= 1'b0;
            N    <= res_fin_c[WIDTH-1];
            Z    <= (res_fin_c == '0);
            V    <= 1'b0;
          end
          default: begin
            F    <= res_fin_c;
            Cout <= sl_cout;
            N    <= res_fin_c[WIDTH-1];
            Z    <= (res_fin_c == '0);
            V    <= SIGNED_EN & (sl_cmsb ^ sl_cout);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit at WIDTH=8, SLICE=2 (ALU_SEQ_SIGNED_EN aware).
module tb_alu_seq_nbit;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
`ifdef ALU_SEQ_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Cin, out_valid, out_ready;
  logic         Cout, N, Z, V;
  logic [W-1:0] A, B, F;
  logic [1:0]   M;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  alu_seq_nbit #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .M         (M),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Cout      (Cout),
    .N         (N),
    .Z         (Z),
    .V         (V)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [1:0] m);
    A = a; B = b; Cin = cin; M = m; in_valid = 1'b1;
    check("start.in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, 4);
  endtask

  task automatic check_res(input string tag, input logic [7:0] ef, input logic ec,
                           input logic en, input logic ez, input logic ev);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".F"}, F, ef);
    check({tag, ".Cout"}, Cout, ec);
    check({tag, ".N"}, N, en);
    check({tag, ".Z"}, Z, ez);
    check({tag, ".V"}, V, ev);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".rel_out_valid"}, out_valid, 0);
    check({tag, ".rel_in_ready"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [1:0] m, input logic [7:0] ef,
                     input logic ec, input logic en, input logic ez, input logic ev);
    start(a, b, cin, m);
    wait_out(tag);
    check_res(tag, ef, ec, en, ez, ev);
    release_out(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; M = 2'b00;
    step();
    step();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.F", F, 0);
    check("rst.flags", {Cout, N, Z, V}, 4'b0000);
    rst = 1'b0;
    step();

    //    tag        A      B      Cin   M      F      Cout  N     Z     V
    run("add",    8'hF0, 8'h20, 1'b0, 2'b00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    run("sub_neg", 8'h05, 8'h07, 1'b0, 2'b01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    run("sub_zero", 8'h07, 8'h07, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run("cmp_eq", 8'h3C, 8'h3C, 1'b0, 2'b10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run("cmp_msb", 8'h80, 8'h7F, 1'b0, 2'b10, 8'h00, !SGN, SGN, 1'b0, 1'b0);
    run("cmp_lt", 8'h12, 8'h21, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run("and",    8'hCA, 8'h0F, 1'b0, 2'b11, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    run("add_ovf", 8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b0, 1'b1, 1'b0, SGN);

    // Backpressure: result held while in_valid pulses are ignored
    start(8'h12, 8'h34, 1'b1, 2'b00);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      A = 8'hFF;
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
      check("bp.F", F, 8'h47);
      step();
    end
    in_valid = 1'b0;
    check_res("bp_end", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("bp");
    step();
    check("bp.idle_out_valid", out_valid, 0);
    check("bp.idle_in_ready", in_ready, 1);

    // Reset after two slices aborts the operation
    start(8'hFF, 8'hFF, 1'b1, 2'b00);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst.out_valid", out_valid, 0);
    check("mrst.in_ready", in_ready, 1);
    check("mrst.F", F, 0);
    check("mrst.flags", {Cout, N, Z, V}, 4'b0000);
    run("post_rst", 8'h01, 8'h01, 1'b0, 2'b00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
